decode_issue: RTL and testbench

//  Decode/issue stage directly upstream of the ALU. Accepts RV32I OP (0110011) and OP-IMM (0010011)

---
 rtl/decode_issue.sv | 156 +++++++++++++++
 tb/tb_decode_issue.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue.sv
// Decode/issue stage feeding the ALU: RV32I OP / OP-IMM decode, register file read, pending-write scoreboard.
// Latency: one cycle from accept to out_valid; a writeback is bypassed to an operand read in the same cycle.
// Backpressure: in_ready drops while the output register is held (out_valid && !out_ready) or on a RAW hazard.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_ready/in_instr instruction input handshake
//   out_valid/out_ready        issued-operation handshake; out_fn/out_funct7/out_a/out_b/out_rd carry it
//   wb_en/wb_rd/wb_data        writeback port: writes the register file and clears the scoreboard bit
//   illegal                    one-cycle pulse after an unsupported opcode was accepted and dropped
module decode_issue #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_fn,
    output logic [6:0]       out_funct7,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [4:0]       out_rd,
    input  logic             wb_en,
    input  logic [4:0]       wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    output logic             illegal
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    // Entry 0 is reset to zero and never written; reads of x0 are forced to zero anyway.
    logic [WIDTH-1:0] rf_q [32];
    logic [31:0]      pend_q, pend_d;
    logic             out_valid_q, out_valid_d;
    logic             illegal_q, illegal_d;
    logic [2:0]       fn_q;
    logic [6:0]       funct7_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [4:0]       rd_q;

    // Decode fields
    logic [6:0]        opcode;
    logic [4:0]        rs1, rs2, rd;
    logic [2:0]        fn;
    logic              is_op, is_opimm, legal;
    logic signed [11:0] imm12;
    logic [WIDTH-1:0]  imm_ext;
    logic [WIDTH-1:0]  rs1_val, rs2_val, op_b;
    logic [6:0]        funct7;
    logic              wb_hit1, wb_hit2;
    logic              haz1, haz2, hazard;
    logic              space_ok, accept, issue;

    assign opcode   = in_instr[6:0];
    assign rd       = in_instr[11:7];
    assign fn       = in_instr[14:12];
    assign rs1      = in_instr[19:15];
    assign rs2      = in_instr[24:20];
    assign is_op    = (opcode == OPC_OP);
    assign is_opimm = (opcode == OPC_OPIMM);
    assign legal    = is_op || is_opimm;

    // Size cast of a signed value sign-extends (or truncates when WIDTH < 12).
    assign imm12    = in_instr[31:20];
    assign imm_ext  = WIDTH'(imm12);

    // Writeback in the decode cycle is forwarded so a waiting consumer issues without an extra cycle.
    assign wb_hit1  = wb_en && (wb_rd == rs1);
    assign wb_hit2  = wb_en && (wb_rd == rs2);
    assign rs1_val  = (rs1 == 5'd0) ? '0 : (wb_hit1 ? wb_data : rf_q[rs1]);
    assign rs2_val  = (rs2 == 5'd0) ? '0 : (wb_hit2 ? wb_data : rf_q[rs2]);
    assign op_b     = is_op ? rs2_val : imm_ext;

    // funct7 reaches the ALU only where it selects a variant (OP, shifts). For ADDI/ANDI/etc. the
    // top immediate bits must not leak through, otherwise a negative ADDI would become a SUB.
    always_comb begin
        funct7 = 7'b0;
        if (is_op || (is_opimm && (fn == 3'b101 || fn == 3'b001))) begin
            funct7 = in_instr[31:25];
        end
    end

    // A pending source is not a hazard when its writeback lands this very cycle (bypass covers it).
    assign haz1     = pend_q[rs1] && (rs1 != 5'd0) && !wb_hit1;
    assign haz2     = is_op && pend_q[rs2] && (rs2 != 5'd0) && !wb_hit2;
    assign hazard   = haz1 || haz2;

    assign space_ok = !out_valid_q || out_ready;
    assign in_ready = !rst && space_ok && !(legal && hazard);
    assign accept   = in_valid && in_ready;
    assign issue    = accept && legal;

    // Next-state for handshake and scoreboard. Clear before set so an issue to wb_rd wins.
    always_comb begin
        out_valid_d = out_valid_q;
        if (issue) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        illegal_d = accept && !legal;

        pend_d = pend_q;
        if (wb_en) begin
            pend_d[wb_rd] = 1'b0;
        end
        if (issue && (rd != 5'd0)) begin
            pend_d[rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            pend_q      <= '0;
            fn_q        <= '0;
            funct7_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rd_q        <= '0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            pend_q      <= pend_d;
            if (issue) begin
                fn_q     <= fn;
                funct7_q <= funct7;
                a_q      <= rs1_val;
                b_q      <= op_b;
                rd_q     <= rd;
            end
            if (wb_en && (wb_rd != 5'd0)) begin
                rf_q[wb_rd] <= wb_data;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign illegal    = illegal_q;
    assign out_fn     = fn_q;
    assign out_funct7 = funct7_q;
    assign out_a      = a_q;
    assign out_b      = b_q;
    assign out_rd     = rd_q;

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: hand-written corner sequences, a decode vector table, and randomized
// traffic compared against a reference model built from the architectural rules.
// Inputs change 1 time unit after the rising edge; outputs are sampled there or mid-cycle.
module tb_decode_issue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_fn;
    logic [6:0]  out_funct7;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [4:0]  out_rd;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;

    decode_issue #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_fn(out_fn), .out_funct7(out_funct7), .out_a(out_a), .out_b(out_b), .out_rd(out_rd),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- decode vector table ----------------
    typedef struct {
        logic [31:0] instr;
        logic        legal;
        logic [2:0]  fn;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } vec_t;

    vec_t tbl[11];

    // ---------------- reference model state ----------------
    logic [31:0] m_rf [32];
    bit          m_pend [32];
    bit          m_vld, m_ill;
    logic [2:0]  m_fn;
    logic [6:0]  m_f7;
    logic [31:0] m_a, m_b;
    logic [4:0]  m_rd;

    function automatic logic [31:0] m_val(input logic [4:0] r);
        if (r == 0) return 32'd0;
        if (wb_en && wb_rd == r) return wb_data;
        return m_rf[r];
    endfunction

    function automatic bit m_busy(input logic [4:0] r);
        return (r != 0) && m_pend[r] && !(wb_en && wb_rd == r);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_rf[i] = 32'd0;
            m_pend[i] = 1'b0;
        end
        m_vld = 0; m_ill = 0; m_fn = 0; m_f7 = 0; m_a = 0; m_b = 0; m_rd = 0;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [6:0] f7;
        logic [6:0] bad [5];
        int kind;
        bad[0] = 7'h6F; bad[1] = 7'h03; bad[2] = 7'h23; bad[3] = 7'h63; bad[4] = 7'h37;
        kind = $urandom_range(0, 19);
        case ($urandom_range(0, 2))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        if (kind < 9)
            return {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
                    5'($urandom_range(0, 7)), 7'h33};
        else if (kind < 18)
            return {f7, 5'($urandom), 5'($urandom_range(0, 7)), 3'($urandom),
                    5'($urandom_range(0, 7)), 7'h13};
        else
            return {25'($urandom), bad[$urandom_range(0, 4)]};
    endfunction

    initial begin
        // ADDI x1,x0,-5 ; SRAI x4,x5,3 ; SUB x6,x7,x8 ; SLLI x10,x11,7 ; SLLI with funct7 bits
        // ANDI x12,x13,-1 ; ADDI x14,x15,-2048 ; SRLI x16,x17,31 ; OR x18,x19,x20 ; OP funct7=1 ; JAL
        // Register preload is x_i = 0x100 + i. For shifts, b is the full sign-extended immediate;
        // the shift amount is its low five bits.
        tbl[0]  = '{32'hFFB00093, 1'b1, 3'b000, 7'h00, 32'h0,   32'hFFFFFFFB, 5'd1};
        tbl[1]  = '{32'h4032D213, 1'b1, 3'b101, 7'h20, 32'h105, 32'h00000403, 5'd4};
        tbl[2]  = '{32'h40838333, 1'b1, 3'b000, 7'h20, 32'h107, 32'h108,      5'd6};
        tbl[3]  = '{32'h00759513, 1'b1, 3'b001, 7'h00, 32'h10B, 32'h7,        5'd10};
        tbl[4]  = '{32'h40759513, 1'b1, 3'b001, 7'h20, 32'h10B, 32'h407,      5'd10};
        tbl[5]  = '{32'hFFF6F613, 1'b1, 3'b111, 7'h00, 32'h10D, 32'hFFFFFFFF, 5'd12};
        tbl[6]  = '{32'h80078713, 1'b1, 3'b000, 7'h00, 32'h10F, 32'hFFFFF800, 5'd14};
        tbl[7]  = '{32'h01F8D813, 1'b1, 3'b101, 7'h00, 32'h111, 32'h1F,       5'd16};
        tbl[8]  = '{32'h0149E933, 1'b1, 3'b110, 7'h00, 32'h113, 32'h114,      5'd18};
        tbl[9]  = '{32'h037B0AB3, 1'b1, 3'b000, 7'h01, 32'h116, 32'h117,      5'd21};
        tbl[10] = '{32'h0000006F, 1'b0, 3'b000, 7'h00, 32'h0,   32'h0,        5'd0};

        // ---------------- reset ----------------
        rst = 1; in_valid = 1; in_instr = 32'hFFB00093; out_ready = 1;
        wb_en = 0; wb_rd = 0; wb_data = 0;
        cyc(); cyc();
        #2 chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_fn", {29'd0, out_fn}, 32'd0);
        chk("rst_funct7", {25'd0, out_funct7}, 32'd0);
        chk("rst_a", out_a, 32'd0);
        chk("rst_b", out_b, 32'd0);
        chk("rst_rd", {27'd0, out_rd}, 32'd0);
        cyc();
        rst = 0;

        // ---------------- ADDI x1,x0,-5 ----------------
        #2 chk("addi_in_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        chk("addi_valid", {31'd0, out_valid}, 32'd1);
        chk("addi_fn", {29'd0, out_fn}, 32'd0);
        chk("addi_funct7", {25'd0, out_funct7}, 32'd0);
        chk("addi_a", out_a, 32'd0);
        chk("addi_b", out_b, 32'hFFFFFFFB);
        chk("addi_rd", {27'd0, out_rd}, 32'd1);

        // ---------------- RAW stall released by same-cycle writeback ----------------
        in_instr = 32'h002081B3;                    // ADD x3,x1,x2
        #2 chk("raw_stall", {31'd0, in_ready}, 32'd0);
        wb_en = 1; wb_rd = 1; wb_data = 32'd7;
        #1 chk("raw_bypass_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        wb_en = 0;
        chk("raw_bypass_a", out_a, 32'd7);
        chk("raw_bypass_b", out_b, 32'd0);
        chk("raw_bypass_rd", {27'd0, out_rd}, 32'd3);

        // ---------------- output held under backpressure, then no-bubble transfer ----------------
        in_instr = 32'h00A00293;                    // ADDI x5,x0,10
        cyc();
        out_ready = 0;
        in_instr = 32'h01400313;                    // ADDI x6,x0,20
        for (int i = 0; i < 4; i++) begin
            #2 chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            cyc();
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_b", out_b, 32'd10);
            chk("hold_rd", {27'd0, out_rd}, 32'd5);
        end
        out_ready = 1;
        #2 chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        chk("b2b_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_b", out_b, 32'd20);
        chk("b2b_rd", {27'd0, out_rd}, 32'd6);
        in_valid = 0;
        cyc();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);

        // ---------------- illegal opcode (JAL x7) ----------------
        in_valid = 1; in_instr = 32'h000003EF;
        cyc();
        in_valid = 0;
        chk("jal_illegal", {31'd0, illegal}, 32'd1);
        chk("jal_valid", {31'd0, out_valid}, 32'd0);
        cyc();
        chk("jal_illegal_pulse", {31'd0, illegal}, 32'd0);
        in_valid = 1; in_instr = 32'h00038433;      // ADD x8,x7,x0: x7 must not be pending
        #2 chk("jal_no_pending", {31'd0, in_ready}, 32'd1);
        cyc();
        in_instr = 32'h00100013;                    // ADDI x0,x0,1
        cyc();
        chk("x0_rd", {27'd0, out_rd}, 32'd0);
        chk("x0_b", out_b, 32'd1);

        // ---------------- same-edge writeback and issue to x9: set wins ----------------
        wb_en = 1; wb_rd = 9; wb_data = 32'h55;
        in_instr = 32'h00100493;                    // ADDI x9,x0,1
        #2 chk("same_edge_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        wb_en = 0;
        in_instr = 32'h00048533;                    // ADD x10,x9,x0
        #2 chk("set_wins", {31'd0, in_ready}, 32'd0);

        // ---------------- reset during a stall ----------------
        in_valid = 0; out_ready = 0;
        cyc();
        rst = 1;
        cyc();
        rst = 0;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_a", out_a, 32'd0);
        chk("midrst_b", out_b, 32'd0);
        chk("midrst_rd", {27'd0, out_rd}, 32'd0);
        in_valid = 1; out_ready = 1;
        #2 chk("midrst_pending_clr", {31'd0, in_ready}, 32'd1);
        cyc();
        in_valid = 0;
        chk("midrst_rf_zero", out_a, 32'd0);       // x9 held 0x55 before reset

        // ---------------- decode table ----------------
        for (int i = 1; i < 32; i++) begin
            wb_en = 1; wb_rd = 5'(i); wb_data = 32'h100 + i;
            cyc();
        end
        wb_en = 0;
        for (int i = 0; i < 11; i++) begin
            in_valid = 1; in_instr = tbl[i].instr; out_ready = 1;
            #2 chk($sformatf("tbl%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            cyc();
            in_valid = 0;
            chk($sformatf("tbl%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].legal});
            chk($sformatf("tbl%0d_illegal", i), {31'd0, illegal}, {31'd0, !tbl[i].legal});
            if (tbl[i].legal) begin
                chk($sformatf("tbl%0d_fn", i), {29'd0, out_fn}, {29'd0, tbl[i].fn});
                chk($sformatf("tbl%0d_funct7", i), {25'd0, out_funct7}, {25'd0, tbl[i].f7});
                chk($sformatf("tbl%0d_a", i), out_a, tbl[i].a);
                chk($sformatf("tbl%0d_b", i), out_b, tbl[i].b);
                chk($sformatf("tbl%0d_rd", i), {27'd0, out_rd}, {27'd0, tbl[i].rd});
                if (tbl[i].rd != 0) begin
                    wb_en = 1; wb_rd = tbl[i].rd; wb_data = 32'h100 + tbl[i].rd;
                end
            end
            cyc();
            wb_en = 0;
        end

        // ---------------- randomized traffic vs reference model ----------------
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [4:0] pq [$];
            logic [6:0] opc;
            logic [4:0] r1, r2, rdx;
            logic       lg, hz, exp_rdy, acc;
            rst       = (c == 0) || ($urandom_range(0, 199) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_instr  = gen_instr();
            out_ready = ($urandom_range(0, 9) < 6);
            wb_en     = ($urandom_range(0, 9) < 4);
            for (int r = 1; r < 32; r++) if (m_pend[r]) pq.push_back(5'(r));
            if (pq.size() > 0 && $urandom_range(0, 3) != 0)
                wb_rd = pq[$urandom_range(0, pq.size() - 1)];
            else
                wb_rd = 5'($urandom_range(0, 7));
            wb_data = $urandom;

            opc = in_instr[6:0];
            r1  = in_instr[19:15];
            r2  = in_instr[24:20];
            rdx = in_instr[11:7];
            lg  = (opc == 7'h33) || (opc == 7'h13);
            hz  = m_busy(r1) || ((opc == 7'h33) && m_busy(r2));
            exp_rdy = !rst && (!m_vld || out_ready) && !(lg && hz);
            acc = in_valid && exp_rdy;

            #2 chk("rnd_in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});

            if (rst) begin
                m_reset();
            end else begin
                m_ill = acc && !lg;
                if (acc && lg) begin
                    m_vld = 1;
                    m_fn  = in_instr[14:12];
                    m_f7  = ((opc == 7'h33) || m_fn == 3'd1 || m_fn == 3'd5) ? in_instr[31:25] : 7'd0;
                    m_a   = m_val(r1);
                    m_b   = (opc == 7'h33) ? m_val(r2) : {{20{in_instr[31]}}, in_instr[31:20]};
                    m_rd  = rdx;
                end else if (out_ready) begin
                    m_vld = 0;
                end
                if (wb_en) m_pend[wb_rd] = 0;
                if (acc && lg && rdx != 0) m_pend[rdx] = 1;
                if (wb_en && wb_rd != 0) m_rf[wb_rd] = wb_data;
            end

            cyc();
            chk("rnd_valid", {31'd0, out_valid}, {31'd0, m_vld});
            chk("rnd_illegal", {31'd0, illegal}, {31'd0, m_ill});
            chk("rnd_fn", {29'd0, out_fn}, {29'd0, m_fn});
            chk("rnd_funct7", {25'd0, out_funct7}, {25'd0, m_f7});
            chk("rnd_a", out_a, m_a);
            chk("rnd_b", out_b, m_b);
            chk("rnd_rd", {27'd0, out_rd}, {27'd0, m_rd});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
